// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares a single-port asynchronous program ROM between
// instruction fetch (P0) and data load (P1), with registered per-port responses.
module rom_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2048
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p0_req,
    input  logic [WIDTH-1:0] p0_addr,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    output logic             p0_err,
    input  logic             p1_req,
    input  logic [WIDTH-1:0] p1_addr,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             p1_err,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata,
    output logic [15:0]      conflict_cnt
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    // Misaligned or beyond the last ROM word.
    function automatic logic addr_err(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WIDTH-1:2]} >= DEPTH_W);
    endfunction

    port_e            last_gnt_r;
    logic [WIDTH-1:0] held_addr_r;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             any_gnt_s;
    logic [WIDTH-1:0] sel_addr_s;
    logic [WIDTH-1:0] word_addr_s;
    logic             sel_err_s;
    logic [WIDTH-1:0] resp_data_s;
    logic             conflict_s;

    // Arbitration: lone requester wins, contention goes to the port not granted last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (p0_req && p1_req) begin
            if (last_gnt_r == PORT1) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (p0_req) begin
            gnt0_s = 1'b1;
        end else if (p1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // ROM address mux and error/response data for the granted request.
    always_comb begin
        any_gnt_s   = gnt0_s | gnt1_s;
        sel_addr_s  = gnt1_s ? p1_addr : p0_addr;
        word_addr_s = {sel_addr_s[WIDTH-1:2], 2'b00};
        sel_err_s   = addr_err(sel_addr_s);
        conflict_s  = p0_req & p1_req;
        if (sel_err_s) begin
            resp_data_s = {WIDTH{1'b0}};
        end else begin
            resp_data_s = rom_rdata;
        end
        if (any_gnt_s) begin
            rom_address = word_addr_s;
        end else begin
            rom_address = held_addr_r;
        end
    end

    assign p0_gnt = gnt0_s;
    assign p1_gnt = gnt1_s;

    // Response registers, arbitration history, held address and conflict counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_r   <= PORT1;
            held_addr_r  <= {WIDTH{1'b0}};
            p0_rvalid    <= 1'b0;
            p0_rdata     <= {WIDTH{1'b0}};
            p0_err       <= 1'b0;
            p1_rvalid    <= 1'b0;
            p1_rdata     <= {WIDTH{1'b0}};
            p1_err       <= 1'b0;
            conflict_cnt <= 16'h0000;
        end else begin
            p0_rvalid <= gnt0_s;
            p1_rvalid <= gnt1_s;
            if (gnt0_s) begin
                p0_rdata <= resp_data_s;
                p0_err   <= sel_err_s;
            end
            if (gnt1_s) begin
                p1_rdata <= resp_data_s;
                p1_err   <= sel_err_s;
            end
            if (any_gnt_s) begin
                held_addr_r <= word_addr_s;
                last_gnt_r  <= gnt1_s ? PORT1 : PORT0;
            end
            // Saturating count of contention cycles.
            if (conflict_s && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter; ROM word w reads as 32'hC0DE_0000 | w.
module tb_rom_arbiter;

    logic        clock;
    logic        reset;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;
    logic        p1_req;
    logic [31:0] p1_addr;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;
    logic [31:0] rom_address;
    logic [31:0] rom_rdata;
    logic [15:0] conflict_cnt;

    int total;
    int bad;

    rom_arbiter #(.WIDTH(32), .DEPTH(2048)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .rom_address(rom_address), .rom_rdata(rom_rdata),
        .conflict_cnt(conflict_cnt)
    );

    assign rom_rdata = 32'hC0DE_0000 | {16'h0000, rom_address[17:2]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset   = 1'b1;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        p0_addr = 32'h0000_0010;
        p1_addr = 32'h0000_0020;
        @(posedge clock);
        @(negedge clock);
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL reset_gnt got %b want 00", {p0_gnt, p1_gnt});
        end
        reset  = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        #1;
        total++;
        if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err});
        end
        total++;
        if ({p0_rdata, p1_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata got %h %h want 0 0", p0_rdata, p1_rdata);
        end
        total++;
        if (conflict_cnt !== 16'h0000 || rom_address !== 32'h0) begin
            bad++;
            $display("FAIL reset_cnt_addr got %h %h want 0000 0", conflict_cnt, rom_address);
        end
    endtask

    task automatic test_single();
        @(negedge clock);
        p0_req  = 1'b1;
        p0_addr = 32'h0000_0010;
        #1;
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b10 || rom_address !== 32'h0000_0010) begin
            bad++;
            $display("FAIL single_gnt got %b %h want 10 00000010", {p0_gnt, p1_gnt}, rom_address);
        end
        @(posedge clock);
        #1;
        total++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hC0DE_0004 || p0_err !== 1'b0 || p1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_resp got %b %h %b want 1 c0de0004 0", p0_rvalid, p0_rdata, p0_err);
        end
        @(negedge clock);
        p0_req = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hC0DE_0004) begin
            bad++;
            $display("FAIL single_pulse got %b %h want 0 c0de0004", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            p0_req  = 1'b1;
            p1_req  = 1'b1;
            p0_addr = 32'h0000_0040;
            p1_addr = 32'h0000_0080;
            exp0    = (i % 2 == 0);
            #1;
            total++;
            if ({p0_gnt, p1_gnt} !== {exp0, ~exp0}) begin
                bad++;
                $display("FAIL contention_gnt%0d got %b want %b", i, {p0_gnt, p1_gnt}, {exp0, ~exp0});
            end
            @(posedge clock);
            #1;
            total++;
            if ({p0_rvalid, p1_rvalid} !== {exp0, ~exp0} ||
                (exp0 && p0_rdata !== 32'hC0DE_0010) || (!exp0 && p1_rdata !== 32'hC0DE_0020)) begin
                bad++;
                $display("FAIL contention_resp%0d got %b %h %h", i, {p0_rvalid, p1_rvalid}, p0_rdata, p1_rdata);
            end
        end
        @(negedge clock);
        p0_req = 1'b0;
        p1_req = 1'b0;
        total++;
        if (conflict_cnt !== 16'd6) begin
            bad++;
            $display("FAIL contention_cnt got %0d want 6", conflict_cnt);
        end
    endtask

    task automatic test_error();
        logic [31:0] addrs [3];
        logic        errs  [3];
        logic [31:0] datas [3];
        addrs = '{32'h0000_0006, 32'h0000_2000, 32'h0000_1FFC};
        errs  = '{1'b1, 1'b1, 1'b0};
        datas = '{32'h0, 32'h0, 32'hC0DE_07FF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            p1_req  = 1'b1;
            p1_addr = addrs[i];
            #1;
            total++;
            if (p1_gnt !== 1'b1 || rom_address !== {addrs[i][31:2], 2'b00}) begin
                bad++;
                $display("FAIL error_gnt%0d got %b %h", i, p1_gnt, rom_address);
            end
            @(posedge clock);
            #1;
            total++;
            if (p1_rvalid !== 1'b1 || p1_err !== errs[i] || p1_rdata !== datas[i]) begin
                bad++;
                $display("FAIL error_resp%0d got %b %b %h want 1 %b %h", i, p1_rvalid, p1_err, p1_rdata, errs[i], datas[i]);
            end
        end
        @(negedge clock);
        p1_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            p1_req  = 1'b1;
            p1_addr = 32'(4 * i);
            #1;
            total++;
            if (p1_gnt !== 1'b1) begin
                bad++;
                $display("FAIL b2b_gnt%0d got %b want 1", i, p1_gnt);
            end
            @(posedge clock);
            #1;
            total++;
            if (p1_rvalid !== 1'b1 || p1_rdata !== (32'hC0DE_0000 | 32'(i)) || p1_err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_resp%0d got %b %h %b", i, p1_rvalid, p1_rdata, p1_err);
            end
        end
        @(negedge clock);
        p1_req = 1'b0;
        #1;
        total++;
        if (rom_address !== 32'h0000_000C || p1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL b2b_hold got %h %b want 0000000c 0", rom_address, p1_gnt);
        end
        @(posedge clock);
        #1;
        total++;
        if (p1_rvalid !== 1'b0 || rom_address !== 32'h0000_000C) begin
            bad++;
            $display("FAIL b2b_idle got %b %h want 0 0000000c", p1_rvalid, rom_address);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        p0_req  = 1'b1;
        p0_addr = 32'h0000_0008;
        @(negedge clock);
        p0_addr = 32'h0000_0010;
        #1;
        total++;
        if (p0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midreset_gnt got %b want 1", p0_gnt);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL midreset_forced got %b want 00", {p0_gnt, p1_gnt});
        end
        @(posedge clock);
        #1;
        total++;
        if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000 || p0_rdata !== 32'h0 ||
            p1_rdata !== 32'h0 || conflict_cnt !== 16'h0 || rom_address !== 32'h0) begin
            bad++;
            $display("FAIL midreset_outs got %b %h %h %h %h", {p0_rvalid, p1_rvalid, p0_err, p1_err},
                     p0_rdata, p1_rdata, conflict_cnt, rom_address);
        end
        @(negedge clock);
        reset   = 1'b0;
        p1_req  = 1'b1;
        p1_addr = 32'h0000_0004;
        #1;
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_first got %b want 10", {p0_gnt, p1_gnt});
        end
        @(negedge clock);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clock);
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        p0_addr = 32'h0;
        p1_addr = 32'h4;
        repeat (65534) @(posedge clock);
        @(negedge clock);
        total++;
        if (conflict_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_pre got %h want fffe", conflict_cnt);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if (conflict_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_top got %h want ffff", conflict_cnt);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if (conflict_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_hold got %h want ffff", conflict_cnt);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        p0_req  = 1'b0;
        p1_req  = 1'b0;
        p0_addr = 32'h0;
        p1_addr = 32'h0;
        test_reset();
        test_single();
        test_contention();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
